e_scale_load_ctrl: RTL and testbench
====================================

Name: e_scale_load_ctrl

Overview:
Sequencer that fills the per-tile E-scale tail/rank register bank at the start of every tiling compute and then steps the bank's output row selector during the compute. It fetches 512-bit E-scale words from the on-chip parameter buffer with a request/response handshake. Each word is presented to the bank with the correct set pulse, start index and size for the active precision mode. Once loading is complete, it advances the output row index (1..16) on demand from the output-stage controller.

Parameters:
WORD_W, 512, width of one E-scale tail/rank word
ROWS, 16, output rows per systolic array (row index range 1..ROWS)
SETS, 64, register entries per bank (sa_row_num*row_num)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  one-cycle pulse: begin loading for a new tile
mode  in  1  0 = 8x8 (16-bit tail, 8-bit rank), 1 = 1x8 (32-bit tail set, 16-bit rank set); sampled on start
req_valid  out  1  fetch request valid
req_ready  in  1  buffer accepts request
req_is_rank  out  1  0 = tail word, 1 = rank word
req_idx  out  2  word index within the tail/rank group
rsp_valid  in  1  returned word valid (one per accepted request, any latency ≥1)
rsp_data  in  WORD_W  returned word
mode_o  out  1  mode held for the bank
tail_set  out  1  bank tail write strobe
tail_word  out  WORD_W  tail data to bank
tail_reg_start  out  8  first 1-based entry written
tail_reg_size  out  8  entry count
rank_set  out  1  bank rank write strobe
rank_word  out  WORD_W  rank data to bank
rank_reg_start  out  8  first 1-based entry written
rank_reg_size  out  8  entry count
loaded  out  1  level: bank fully written, sweep allowed
row_step  in  1  advance output row
out_sa_row_idx  out  6  row select to bank; 0 = none
row_last  out  1  high while out_sa_row_idx == ROWS

Behaviour:
- Reset: every output is 0; state is IDLE; the latched mode is 0.
- States: IDLE → TAIL_REQ ↔ TAIL_WAIT → RANK_REQ ↔ RANK_WAIT → READY.
- start in IDLE or READY: latch mode, clear the word counter, set out_sa_row_idx=0 and loaded=0, go to TAIL_REQ. start in any other state is ignored.
- Word counts:
  - Tail: mode0 = 2 words, start 1/33, size 32 each. mode1 = 4 words, start 1/17/33/49, size 16 each.
  - Rank: mode0 = 1 word, start 1, size 64. mode1 = 2 words, start 1/33, size 32 each.
- *_REQ state: req_valid=1 with req_is_rank and req_idx set to the current word number. On req_ready, move to *_WAIT. Only one request is outstanding at a time.
- *_WAIT state: on rsp_valid, register rsp_data into tail_word/rank_word and start/size into the matching outputs. Assert tail_set/rank_set for exactly the next cycle, so the data lands in the bank 2 cycles after rsp_valid.
  - If more words remain: increment the counter and return to *_REQ.
  - If this was the last tail word: reset the counter and go to RANK_REQ.
  - If this was the last rank word: go to READY.
- Word data, start and size outputs hold their last values when not strobed. mode_o holds the latched mode.
- rsp_valid outside a *_WAIT state is ignored.
- Entering READY: loaded=1 and out_sa_row_idx=1 in the same cycle as the final rank_set pulse, so the bank is coherent one cycle later.
- READY sweep: each row_step increments the index; ROWS wraps to 1. row_step in any other state is ignored.
- row_last is combinational from out_sa_row_idx.
- start and row_step in the same READY cycle: start wins.
- reset mid-load: abort immediately with no further strobes. The requester must drop any in-flight response.

Decomposition:
- Shared package: mode encodings, per-mode word counts, start/size constant tables, state enum.
- Sub-module e_scale_row_counter: 1..ROWS wrapping counter with enable/clear, producing out_sa_row_idx and row_last.

Test Plan:
1. mode0, req_ready=1, rsp 1 cycle later → 2 tail pulses (start 1/33, size 32), then 1 rank pulse (start 1, size 64); loaded=1, idx=1; exactly 3 requests, req_idx 0,1,0.
2. mode1 → tail starts 1,17,33,49 at size 16, then rank starts 1,33 at size 32; 6 set pulses total; each data word equals the rsp_data returned for that request.
3. Backpressure: req_ready low 5 cycles, rsp latency 7 → req_valid held stable, no strobes until response, ordering preserved.
4. READY, 17 row_step pulses → idx 1→2…16→1→2; row_last high only at 16.
5. start during TAIL_WAIT, and row_step during load → both ignored; a new start in READY mid-sweep → idx=0, loaded=0, reload begins.
6. reset asserted after first tail pulse → all outputs 0 next cycle; a following spurious rsp_valid produces no strobe.

Source files
------------

// File: rtl/e_scale_load_ctrl_pkg.sv
// Shared definitions for the E-scale tail/rank bank loader: mode encodings,
// per-mode word counts, bank start/size tables and the sequencer state set.
package e_scale_load_ctrl_pkg;

    localparam int WORD_W = 512;
    localparam int ROWS   = 16;
    localparam int SETS   = 64;

    localparam logic MODE_8X8 = 1'b0;
    localparam logic MODE_1X8 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TAIL_REQ,
        ST_TAIL_WAIT,
        ST_RANK_REQ,
        ST_RANK_WAIT,
        ST_READY
    } state_t;

    // 1-based first bank entry covered by each word, indexed by word number
    localparam logic [3:0][7:0] TAIL_START_8X8 = {8'd0, 8'd0, 8'd33, 8'd1};
    localparam logic [3:0][7:0] TAIL_START_1X8 = {8'd49, 8'd33, 8'd17, 8'd1};
    localparam logic [3:0][7:0] RANK_START_8X8 = {8'd0, 8'd0, 8'd0, 8'd1};
    localparam logic [3:0][7:0] RANK_START_1X8 = {8'd0, 8'd0, 8'd33, 8'd1};

    // Entries covered by one word
    localparam logic [7:0] TAIL_SIZE_8X8 = 8'(SETS / 2);
    localparam logic [7:0] TAIL_SIZE_1X8 = 8'(SETS / 4);
    localparam logic [7:0] RANK_SIZE_8X8 = 8'(SETS);
    localparam logic [7:0] RANK_SIZE_1X8 = 8'(SETS / 2);

    // Index of the last word of each group
    function automatic logic [1:0] tail_last_idx(input logic m);
        return (m == MODE_1X8) ? 2'd3 : 2'd1;
    endfunction

    function automatic logic [1:0] rank_last_idx(input logic m);
        return (m == MODE_1X8) ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [7:0] tail_start(input logic m, input logic [1:0] idx);
        return (m == MODE_1X8) ? TAIL_START_1X8[idx] : TAIL_START_8X8[idx];
    endfunction

    function automatic logic [7:0] rank_start(input logic m, input logic [1:0] idx);
        return (m == MODE_1X8) ? RANK_START_1X8[idx] : RANK_START_8X8[idx];
    endfunction

    function automatic logic [7:0] tail_size(input logic m);
        return (m == MODE_1X8) ? TAIL_SIZE_1X8 : TAIL_SIZE_8X8;
    endfunction

    function automatic logic [7:0] rank_size(input logic m);
        return (m == MODE_1X8) ? RANK_SIZE_1X8 : RANK_SIZE_8X8;
    endfunction

endpackage

// File: rtl/e_scale_row_counter.sv
// Output row selector: 0 means no row, otherwise counts 1..ROWS and wraps to 1.
module e_scale_row_counter
    import e_scale_load_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       init,
    input  logic       step,
    output logic [5:0] row_idx,
    output logic       row_last
);

    logic [5:0] row_idx_reg;

    // Clear has priority over init, init over step
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            row_idx_reg <= '0;
        end else if (init) begin
            row_idx_reg <= 6'd1;
        end else if (step) begin
            row_idx_reg <= (row_idx_reg == 6'(ROWS)) ? 6'd1 : row_idx_reg + 6'd1;
        end
    end

    assign row_idx  = row_idx_reg;
    assign row_last = (row_idx_reg == 6'(ROWS));

endmodule

// File: rtl/e_scale_load_ctrl.sv
// Fetches E-scale tail then rank words, strobes each into the bank with its
// start/size, then steps the bank's output row selector on demand.
module e_scale_load_ctrl
    import e_scale_load_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_is_rank,
    output logic [1:0]        req_idx,
    input  logic              rsp_valid,
    input  logic [WORD_W-1:0] rsp_data,
    output logic              mode_o,
    output logic              tail_set,
    output logic [WORD_W-1:0] tail_word,
    output logic [7:0]        tail_reg_start,
    output logic [7:0]        tail_reg_size,
    output logic              rank_set,
    output logic [WORD_W-1:0] rank_word,
    output logic [7:0]        rank_reg_start,
    output logic [7:0]        rank_reg_size,
    output logic              loaded,
    input  logic              row_step,
    output logic [5:0]        out_sa_row_idx,
    output logic              row_last
);

    state_t            state_reg, state_next;
    logic [1:0]        cnt_reg, cnt_next;
    logic              mode_reg, mode_next;
    logic              tail_set_reg, rank_set_reg, loaded_reg;
    logic [WORD_W-1:0] tail_word_reg, rank_word_reg;
    logic [7:0]        tail_start_reg, tail_size_reg;
    logic [7:0]        rank_start_reg, rank_size_reg;

    logic tail_cap, rank_cap, load_begin, load_done, row_adv;

    // State, word counter and latched mode
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            mode_reg  <= MODE_8X8;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            mode_reg  <= mode_next;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mode_next  = mode_reg;
        req_valid  = 1'b0;
        tail_cap   = 1'b0;
        rank_cap   = 1'b0;
        load_begin = 1'b0;
        load_done  = 1'b0;
        row_adv    = 1'b0;
        case (state_reg)
            ST_IDLE, ST_READY: begin
                if (start) begin
                    mode_next  = mode;
                    cnt_next   = '0;
                    load_begin = 1'b1;
                    state_next = ST_TAIL_REQ;
                end else if (state_reg == ST_READY && row_step) begin
                    row_adv = 1'b1;
                end
            end
            ST_TAIL_REQ: begin
                req_valid = 1'b1;
                if (req_ready) state_next = ST_TAIL_WAIT;
            end
            ST_TAIL_WAIT: begin
                if (rsp_valid) begin
                    tail_cap = 1'b1;
                    if (cnt_reg == tail_last_idx(mode_reg)) begin
                        cnt_next   = '0;
                        state_next = ST_RANK_REQ;
                    end else begin
                        cnt_next   = cnt_reg + 2'd1;
                        state_next = ST_TAIL_REQ;
                    end
                end
            end
            ST_RANK_REQ: begin
                req_valid = 1'b1;
                if (req_ready) state_next = ST_RANK_WAIT;
            end
            ST_RANK_WAIT: begin
                if (rsp_valid) begin
                    rank_cap = 1'b1;
                    if (cnt_reg == rank_last_idx(mode_reg)) begin
                        load_done  = 1'b1;
                        state_next = ST_READY;
                    end else begin
                        cnt_next   = cnt_reg + 2'd1;
                        state_next = ST_RANK_REQ;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Capture returned words with their placement; strobes last one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            tail_set_reg   <= 1'b0;
            rank_set_reg   <= 1'b0;
            tail_word_reg  <= '0;
            rank_word_reg  <= '0;
            tail_start_reg <= '0;
            tail_size_reg  <= '0;
            rank_start_reg <= '0;
            rank_size_reg  <= '0;
            loaded_reg     <= 1'b0;
        end else begin
            tail_set_reg <= tail_cap;
            rank_set_reg <= rank_cap;
            if (tail_cap) begin
                tail_word_reg  <= rsp_data;
                tail_start_reg <= tail_start(mode_reg, cnt_reg);
                tail_size_reg  <= tail_size(mode_reg);
            end
            if (rank_cap) begin
                rank_word_reg  <= rsp_data;
                rank_start_reg <= rank_start(mode_reg, cnt_reg);
                rank_size_reg  <= rank_size(mode_reg);
            end
            if (load_begin) begin
                loaded_reg <= 1'b0;
            end else if (load_done) begin
                loaded_reg <= 1'b1;
            end
        end
    end

    e_scale_row_counter u_row_counter (
        .clk      (clk),
        .reset    (reset),
        .clr      (load_begin),
        .init     (load_done),
        .step     (row_adv),
        .row_idx  (out_sa_row_idx),
        .row_last (row_last)
    );

    assign req_is_rank    = (state_reg == ST_RANK_REQ);
    assign req_idx        = req_valid ? cnt_reg : 2'd0;
    assign mode_o         = mode_reg;
    assign tail_set       = tail_set_reg;
    assign tail_word      = tail_word_reg;
    assign tail_reg_start = tail_start_reg;
    assign tail_reg_size  = tail_size_reg;
    assign rank_set       = rank_set_reg;
    assign rank_word      = rank_word_reg;
    assign rank_reg_start = rank_start_reg;
    assign rank_reg_size  = rank_size_reg;
    assign loaded         = loaded_reg;

endmodule

// File: tb/tb_e_scale_load_ctrl.sv
// Directed bench for the E-scale bank loader: load sequences in both modes,
// backpressure, row sweep, ignored start/row_step, and reset mid-load.
module tb_e_scale_load_ctrl;
    import e_scale_load_ctrl_pkg::*;

    logic              clk = 1'b0;
    logic              reset, start, mode, req_ready, rsp_valid, row_step;
    logic              req_valid, req_is_rank, mode_o, tail_set, rank_set, loaded, row_last;
    logic [1:0]        req_idx;
    logic [WORD_W-1:0] rsp_data, tail_word, rank_word;
    logic [7:0]        tail_reg_start, tail_reg_size, rank_reg_start, rank_reg_size;
    logic [5:0]        out_sa_row_idx;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    e_scale_load_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_rank(req_is_rank),
        .req_idx(req_idx), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mode_o(mode_o), .tail_set(tail_set), .tail_word(tail_word),
        .tail_reg_start(tail_reg_start), .tail_reg_size(tail_reg_size),
        .rank_set(rank_set), .rank_word(rank_word),
        .rank_reg_start(rank_reg_start), .rank_reg_size(rank_reg_size),
        .loaded(loaded), .row_step(row_step),
        .out_sa_row_idx(out_sa_row_idx), .row_last(row_last)
    );

    task automatic chk(input string tag, input logic [WORD_W-1:0] got, input logic [WORD_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Distinct data per tile (salt) and per request number (k)
    function automatic logic [WORD_W-1:0] pat(input logic [7:0] salt, input int k);
        logic [31:0] w;
        w = {salt, 8'(k), 16'hC3A5};
        return {16{w}};
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_valid"}, req_valid, 0);
        chk({tag, "_req_is_rank"}, req_is_rank, 0);
        chk({tag, "_req_idx"}, req_idx, 0);
        chk({tag, "_mode_o"}, mode_o, 0);
        chk({tag, "_tail_set"}, tail_set, 0);
        chk({tag, "_tail_word"}, tail_word, 0);
        chk({tag, "_tail_start"}, tail_reg_start, 0);
        chk({tag, "_tail_size"}, tail_reg_size, 0);
        chk({tag, "_rank_set"}, rank_set, 0);
        chk({tag, "_rank_word"}, rank_word, 0);
        chk({tag, "_rank_start"}, rank_reg_start, 0);
        chk({tag, "_rank_size"}, rank_reg_size, 0);
        chk({tag, "_loaded"}, loaded, 0);
        chk({tag, "_row_idx"}, out_sa_row_idx, 0);
        chk({tag, "_row_last"}, row_last, 0);
    endtask

    // Start a tile load and act as the parameter buffer until the last strobe.
    // rdy_wait: cycles req_valid is held before req_ready; lat: response latency.
    task automatic load_tile(input logic m, input int rdy_wait, input int lat, input logic [7:0] salt,
                             input bit step_with_start, input bit inject, input bit stop_after_tail);
        int nt, nr, nreq, tcnt, rcnt, wait_cnt, lat_cnt, cur_k;
        bit pend, rsp_prev, done, injected;
        nt = m ? 4 : 2;
        nr = m ? 2 : 1;
        nreq = 0; tcnt = 0; rcnt = 0; wait_cnt = 0; lat_cnt = 0; cur_k = 0;
        pend = 0; rsp_prev = 0; done = 0; injected = 0;
        mode = m; start = 1'b1; row_step = step_with_start;
        @(negedge clk);
        start = 1'b0; row_step = 1'b0;
        chk("mode_o_latched", mode_o, m);
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            bit exp_t, exp_r, fin;
            exp_t = rsp_prev && (cur_k < nt);
            exp_r = rsp_prev && (cur_k >= nt);
            fin   = exp_r && (cur_k == nt + nr - 1);
            chk("tail_set", tail_set, exp_t);
            chk("rank_set", rank_set, exp_r);
            chk("loaded", loaded, fin);
            chk("row_idx_load", out_sa_row_idx, fin ? 6'd1 : 6'd0);
            if (tail_set) begin
                $display("tail word %0d: start=%0d size=%0d", tcnt, tail_reg_start, tail_reg_size);
                chk("tail_word", tail_word, pat(salt, tcnt));
                chk("tail_start", tail_reg_start, m ? 1 + 16 * tcnt : 1 + 32 * tcnt);
                chk("tail_size", tail_reg_size, m ? 16 : 32);
                tcnt++;
                if (stop_after_tail) done = 1;
            end
            if (rank_set) begin
                $display("rank word %0d: start=%0d size=%0d", rcnt, rank_reg_start, rank_reg_size);
                chk("rank_word", rank_word, pat(salt, nt + rcnt));
                chk("rank_start", rank_reg_start, m ? 1 + 32 * rcnt : 1);
                chk("rank_size", rank_reg_size, m ? 32 : 64);
                rcnt++;
                if (rcnt == nr) done = 1;
            end
            rsp_prev = 0; rsp_valid = 1'b0; req_ready = 1'b0; start = 1'b0; row_step = 1'b0;
            if (!done) begin
                if (pend) begin
                    chk("single_outstanding", req_valid, 0);
                    lat_cnt++;
                    if (inject && !injected && lat_cnt == 1) begin
                        start = 1'b1; mode = ~m; row_step = 1'b1; injected = 1;
                    end
                    if (lat_cnt == lat) begin
                        rsp_valid = 1'b1; rsp_data = pat(salt, cur_k); pend = 0; rsp_prev = 1;
                    end
                end else if (req_valid) begin
                    chk("req_is_rank", req_is_rank, nreq >= nt);
                    chk("req_idx", req_idx, (nreq >= nt) ? nreq - nt : nreq);
                    if (wait_cnt >= rdy_wait) begin
                        $display("request %0d: is_rank=%0d idx=%0d", nreq, req_is_rank, req_idx);
                        req_ready = 1'b1; pend = 1; lat_cnt = 0; wait_cnt = 0;
                        cur_k = nreq; nreq++;
                    end else begin
                        wait_cnt++;
                    end
                end
                @(negedge clk);
            end
        end
        chk("load_done", done, 1);
        if (!stop_after_tail) begin
            chk("req_count", nreq, nt + nr);
            chk("tail_count", tcnt, nt);
            chk("rank_count", rcnt, nr);
            chk("mode_o_held", mode_o, m);
            chk("tail_word_held", tail_word, pat(salt, nt - 1));
            chk("row_last_after_load", row_last, 0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0; req_ready = 1'b0;
        rsp_valid = 1'b0; rsp_data = '0; row_step = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // mode0 and mode1 back to back, no backpressure
        load_tile(1'b0, 0, 1, 8'h11, 0, 0, 0);
        load_tile(1'b1, 0, 1, 8'h22, 0, 0, 0);
        // backpressure and long response latency
        load_tile(1'b1, 5, 7, 8'h33, 0, 0, 0);

        // row sweep 1..16 with wrap
        for (int k = 1; k <= 17; k++) begin
            row_step = 1'b1;
            @(negedge clk);
            row_step = 1'b0;
            $display("row_step %0d: idx=%0d last=%0d", k, out_sa_row_idx, row_last);
            chk("sweep_idx", out_sa_row_idx, (k % 16) + 1);
            chk("sweep_last", row_last, ((k % 16) + 1) == 16);
        end

        // restart mid-sweep with row_step together; start/row_step during load ignored
        load_tile(1'b0, 1, 3, 8'h44, 1, 1, 0);

        // reset after the first tail strobe, then a stray response
        load_tile(1'b1, 0, 2, 8'h55, 0, 0, 1);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("abort");
        reset = 1'b0; rsp_valid = 1'b1; rsp_data = pat(8'h66, 1);
        @(negedge clk);
        rsp_valid = 1'b0;
        @(negedge clk);
        chk("stray_tail_set", tail_set, 0);
        chk("stray_rank_set", rank_set, 0);
        chk("stray_tail_word", tail_word, 0);
        chk("stray_req_valid", req_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
